stopwatch_counter: RTL and testbench

STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

---
 rtl/stopwatch_pkg.sv | 7 +
 rtl/bcd_mod_counter.sv | 25 ++
 rtl/stopwatch_counter.sv | 55 +++++
 tb/tb_stopwatch_counter.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared FSM state, BCD digit type and seconds digit limits
package stopwatch_pkg;
  typedef enum logic [1:0] {RUN, PAUSE, ADJUST} state_t;
  typedef logic [3:0] bcd_t;
  localparam bcd_t SEC_ONE_MAX = 4'd9;
  localparam bcd_t SEC_TEN_MAX = 4'd5;
endpackage

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter wrapping LIMIT->00; carry flags the terminal count
module bcd_mod_counter import stopwatch_pkg::*; #(
  parameter int LIMIT = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output bcd_t ones,
  output bcd_t tens,
  output logic carry
);
  localparam bcd_t LIM_ONE = bcd_t'(LIMIT % 10);
  localparam bcd_t LIM_TEN = bcd_t'(LIMIT / 10);
  assign carry = (ones == LIM_ONE) && (tens == LIM_TEN);
  // both digits move together in one edge so no intermediate value is ever visible
  always_ff @(posedge clk) begin
    if (rst) begin
      ones <= '0;
      tens <= '0;
    end else if (en) begin
      ones <= (carry || ones == SEC_ONE_MAX) ? '0 : ones + 4'd1;
      tens <= carry ? '0 : (ones == SEC_ONE_MAX) ? tens + 4'd1 : tens;
    end
  end
endmodule

// File: rtl/stopwatch_counter.sv
// stopwatch_counter: MM:SS BCD stopwatch with pause and adjust; STOPWATCH_SATURATE_EN holds at MIN_LIMIT:59
module stopwatch_counter import stopwatch_pkg::*; #(
  parameter int MIN_LIMIT = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_1hz,
  input  logic tick_2hz,
  input  logic adj,
  input  logic sel,
  input  logic pse,
  output bcd_t sec_one,
  output bcd_t sec_ten,
  output bcd_t min_one,
  output bcd_t min_ten,
  output logic paused
);
`ifdef STOPWATCH_SATURATE_EN
  localparam logic SAT = 1'b1;
`else
  localparam logic SAT = 1'b0;
`endif
  state_t state, state_n;
  logic pause_q, pause_n;
  logic run_tick, adj_tick, sec_en, min_en, sec_carry, min_carry;
  // state and pause flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      pause_q <= 1'b0;
    end else begin
      state   <= state_n;
      pause_q <= pause_n;
    end
  end
  // pse is dropped while adj is high; the new flag steers the next state so pause lands next cycle
  always_comb begin
    pause_n = pause_q ^ (pse & ~adj);
    state_n = adj ? ADJUST : pause_n ? PAUSE : RUN;
  end
  // digit enables: run ticks ripple into minutes, adjust ticks never carry
  always_comb begin
    run_tick = (state == RUN) && tick_1hz && !(SAT && sec_carry && min_carry);
    adj_tick = (state == ADJUST) && tick_2hz;
    sec_en   = run_tick || (adj_tick && sel);
    min_en   = (run_tick && sec_carry) || (adj_tick && !sel && !(SAT && min_carry));
  end
  assign paused = pause_q;
  bcd_mod_counter #(.LIMIT(int'(SEC_TEN_MAX) * 10 + int'(SEC_ONE_MAX))) u_sec (
    .clk(clk), .rst(rst), .en(sec_en), .ones(sec_one), .tens(sec_ten), .carry(sec_carry)
  );
  bcd_mod_counter #(.LIMIT(MIN_LIMIT)) u_min (
    .clk(clk), .rst(rst), .en(min_en), .ones(min_one), .tens(min_ten), .carry(min_carry)
  );
endmodule

// File: tb/tb_stopwatch_counter.sv
// tb_stopwatch_counter: directed stimulus with a queued scoreboard checked at the falling edge
module tb_stopwatch_counter;
  logic clk = 1'b0;
  logic rst, tick_1hz, tick_2hz, adj, sel, pse;
  logic [3:0] sec_one, sec_ten, min_one, min_ten;
  logic paused;
  int checks = 0;
  int failures = 0;
  logic [16:0] exp_q[$];
  string name_q[$];
`ifdef STOPWATCH_SATURATE_EN
  localparam logic [15:0] EXP_TOP = 16'h5959;
  localparam logic [15:0] EXP_SADJ = 16'h5900;
  localparam logic [15:0] EXP_MADJ = 16'h5900;
`else
  localparam logic [15:0] EXP_TOP = 16'h0000;
  localparam logic [15:0] EXP_SADJ = 16'h0001;
  localparam logic [15:0] EXP_MADJ = 16'h0101;
`endif

  stopwatch_counter #(.MIN_LIMIT(59)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .adj(adj), .sel(sel),
    .pse(pse), .sec_one(sec_one), .sec_ten(sec_ten), .min_one(min_one), .min_ten(min_ten),
    .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [15:0] d, input logic p, input string n);
    exp_q.push_back({d, p});
    name_q.push_back(n);
  endtask

  task automatic step(input logic t1, input logic t2, input logic p);
    tick_1hz = t1;
    tick_2hz = t2;
    pse = p;
    @(posedge clk);
    #1;
    tick_1hz = 1'b0;
    tick_2hz = 1'b0;
    pse = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    logic [16:0] e, act;
    string n;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n = name_q.pop_front();
      act = {min_ten, min_one, sec_ten, sec_one, paused};
      checks++;
      if (act !== e) begin
        failures++;
        $display("FAIL %s: got %h paused=%b, expected %h paused=%b", n, act[16:1], act[0], e[16:1], e[0]);
      end
    end
  end

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; tick_2hz = 1'b0; adj = 1'b0; sel = 1'b0; pse = 1'b0;
    @(posedge clk);
    #1;
    step(1, 1, 1);
    push_exp(16'h0000, 1'b0, "reset");
    rst = 1'b0;
    repeat (10) step(1, 0, 0);
    push_exp(16'h0010, 1'b0, "sec_ten carry");
    repeat (50) step(1, 0, 0);
    push_exp(16'h0100, 1'b0, "minute carry");
    step(1, 0, 0);
    push_exp(16'h0101, 1'b0, "61 ticks");
    step(0, 0, 1);
    push_exp(16'h0101, 1'b1, "pause on");
    repeat (5) step(1, 0, 0);
    push_exp(16'h0101, 1'b1, "paused hold");
    step(0, 0, 1);
    push_exp(16'h0101, 1'b0, "pause off");
    step(1, 0, 0);
    push_exp(16'h0102, 1'b0, "resume");
    step(1, 0, 1);
    push_exp(16'h0103, 1'b1, "pse with tick");
    step(1, 0, 0);
    push_exp(16'h0103, 1'b1, "tick after pse");
    step(0, 0, 1);
    push_exp(16'h0103, 1'b0, "unpause");
    adj = 1'b1;
    step(0, 0, 1);
    push_exp(16'h0103, 1'b0, "pse dropped in adjust");
    adj = 1'b0;
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    repeat (58) step(1, 0, 0);
    push_exp(16'h0058, 1'b0, "preset 00:58");
    adj = 1'b1; sel = 1'b1;
    step(0, 0, 0);
    push_exp(16'h0058, 1'b0, "enter adjust");
    repeat (2) step(0, 1, 0);
    push_exp(16'h0000, 1'b0, "sec adjust wrap no carry");
    step(0, 1, 0);
    push_exp(16'h0001, 1'b0, "sec adjust");
    sel = 1'b0;
    step(0, 0, 0);
    push_exp(16'h0001, 1'b0, "sel change without tick");
    step(1, 0, 0);
    push_exp(16'h0001, 1'b0, "tick_1hz ignored in adjust");
    repeat (2) step(0, 1, 0);
    push_exp(16'h0201, 1'b0, "min adjust");
    step(1, 1, 1);
    push_exp(16'h0301, 1'b0, "coincident min adjust");
    sel = 1'b1;
    step(1, 1, 1);
    push_exp(16'h0302, 1'b0, "coincident sec adjust");
    sel = 1'b0;
    repeat (56) step(0, 1, 0);
    sel = 1'b1;
    repeat (57) step(0, 1, 0);
    push_exp(16'h5959, 1'b0, "preload 59:59");
    adj = 1'b0;
    step(0, 0, 0);
    push_exp(16'h5959, 1'b0, "leave adjust");
    step(1, 0, 0);
    push_exp(EXP_TOP, 1'b0, "top of count");
    adj = 1'b1;
    step(0, 0, 0);
    step(0, 1, 0);
    push_exp(EXP_SADJ, 1'b0, "sec adjust at top");
    sel = 1'b0;
    step(0, 1, 0);
    push_exp(EXP_MADJ, 1'b0, "min adjust at top");
    rst = 1'b1;
    step(0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0);
    repeat (12) step(0, 1, 0);
    sel = 1'b1;
    repeat (34) step(0, 1, 0);
    adj = 1'b0;
    step(0, 0, 1);
    push_exp(16'h1234, 1'b1, "12:34 paused");
    step(0, 0, 1);
    push_exp(16'h1234, 1'b0, "12:34 running");
    rst = 1'b1;
    step(1, 0, 0);
    push_exp(16'h0000, 1'b0, "rst beats tick");
    rst = 1'b0;
    step(1, 0, 0);
    push_exp(16'h0001, 1'b0, "run after reset");
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
